// File: rtl/cpu_wait_gen_if.sv
// Shared bus clock bundle: system clock plus the 3.58 MHz CPU clock-enable pulse.
interface clock_bus_if;
    logic clk;
    logic ce_3m58_p;

    modport base_mp (
        input clk,
        input ce_3m58_p
    );
endinterface

// File: rtl/cpu_wait_gen.sv
// Z80 WAIT generator: programmable per-cycle-type base waits, device wait requests,
// external hold lines with a deadlock timeout, and a turbo bypass of the base waits.
module cpu_wait_gen #(
    parameter int unsigned NUM_SRC   = 4,
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned M1_WAITS  = 1,
    parameter int unsigned IO_WAITS  = 1,
    parameter int unsigned MEM_WAITS = 0,
    parameter int unsigned HOLD_MAX  = 255
) (
    clock_bus_if.base_mp                     clock_bus,
    input  logic                             reset,
    input  logic                             m1,
    input  logic                             mreq,
    input  logic                             iorq,
    input  logic                             rd,
    input  logic                             wr,
    input  logic                             turbo,
    input  logic [NUM_SRC-1:0]               src_req,
    input  logic [NUM_SRC-1:0][CNT_W-1:0]    src_waits,
    input  logic [NUM_SRC-1:0]               ext_hold_n,
    output logic                             wait_n,
    output logic                             busy,
    output logic                             timeout
);

    localparam int unsigned HCNT_W = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
    localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(HOLD_MAX - 1);

    typedef enum logic [1:0] {StIdle, StCount, StHold, StDone} state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [HCNT_W-1:0]  hcnt_q;
    logic               act_q;

    logic               act;
    logic               start;
    logic               hold_sel;
    logic [CNT_W-1:0]   base_waits;
    logic [CNT_W-1:0]   dev_waits;
    logic [CNT_W-1:0]   total_waits;

    assign act      = (mreq & (rd | wr | m1)) | (iorq & (rd | wr | m1));
    assign start    = act & ~act_q;
    assign hold_sel = |(src_req & ~ext_hold_n);

    always_comb begin
        base_waits = CNT_W'(MEM_WAITS);
        if (turbo) begin
            base_waits = '0;
        end else if (m1 && mreq) begin
            base_waits = CNT_W'(M1_WAITS);
        end else if (iorq && !m1) begin
            base_waits = CNT_W'(IO_WAITS);
        end else if (iorq && m1) begin
            base_waits = CNT_W'(M1_WAITS);
        end
    end

    // Longest request wins; taking a max instead of a sum keeps the count in range.
    always_comb begin
        dev_waits = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (src_req[i] && (src_waits[i] > dev_waits)) begin
                dev_waits = src_waits[i];
            end
        end
        total_waits = (dev_waits > base_waits) ? dev_waits : base_waits;
    end

    always_ff @(posedge clock_bus.clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            hcnt_q  <= '0;
            act_q   <= 1'b0;
            wait_n  <= 1'b1;
            timeout <= 1'b0;
        end else if (clock_bus.ce_3m58_p) begin
            act_q <= act;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (hold_sel) begin
                            wait_n  <= 1'b0;
                            hcnt_q  <= '0;
                            state_q <= StHold;
                        end else if (total_waits != '0) begin
                            wait_n  <= 1'b0;
                            cnt_q   <= total_waits - CNT_W'(1);
                            state_q <= StCount;
                        end else begin
                            state_q <= StDone;
                        end
                    end
                end
                StCount: begin
                    // Bus released mid-cycle: drop WAIT and rearm for the next start.
                    if (!act) begin
                        wait_n  <= 1'b1;
                        state_q <= StIdle;
                    end else if (cnt_q == '0) begin
                        if (hold_sel) begin
                            hcnt_q  <= '0;
                            state_q <= StHold;
                        end else begin
                            wait_n  <= 1'b1;
                            state_q <= StDone;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                StHold: begin
                    if (!act) begin
                        wait_n  <= 1'b1;
                        state_q <= StIdle;
                    end else if (!hold_sel) begin
                        wait_n  <= 1'b1;
                        state_q <= StDone;
                    end else if (hcnt_q == HOLD_LAST) begin
                        wait_n  <= 1'b1;
                        timeout <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        hcnt_q <= hcnt_q + HCNT_W'(1);
                    end
                end
                StDone: begin
                    if (!act) begin
                        state_q <= StIdle;
                    end
                end
            endcase
        end
    end

    assign busy = (state_q == StCount) | (state_q == StHold);

endmodule

// File: tb/tb_cpu_wait_gen.sv
// Scoreboard bench for cpu_wait_gen: stimulus pushes expected WAIT length per bus cycle,
// an independent monitor measures each cycle and compares when the cycle ends.
module tb_cpu_wait_gen;

    localparam int NS   = 4;
    localparam int CW   = 4;
    localparam int HM   = 255;
    localparam int M1W  = 1;
    localparam int IOW  = 1;
    localparam int MEMW = 0;

    typedef struct {
        int low;
        int tmo;
        int id;
    } exp_t;

    clock_bus_if cbus ();

    logic                    reset;
    logic                    m1, mreq, iorq, rd, wr, turbo;
    logic [NS-1:0]           src_req;
    logic [NS-1:0][CW-1:0]   src_waits;
    logic [NS-1:0]           ext_hold_n;
    logic                    wait_n, busy, timeout;

    cpu_wait_gen #(
        .NUM_SRC   (NS),
        .CNT_W     (CW),
        .M1_WAITS  (M1W),
        .IO_WAITS  (IOW),
        .MEM_WAITS (MEMW),
        .HOLD_MAX  (HM)
    ) dut (
        .clock_bus  (cbus),
        .reset      (reset),
        .m1         (m1),
        .mreq       (mreq),
        .iorq       (iorq),
        .rd         (rd),
        .wr         (wr),
        .turbo      (turbo),
        .src_req    (src_req),
        .src_waits  (src_waits),
        .ext_hold_n (ext_hold_n),
        .wait_n     (wait_n),
        .busy       (busy),
        .timeout    (timeout)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb_q[$];
    int   tmo_model = 0;
    int   txn_id = 0;
    int   ce_div = 0;

    initial cbus.clk = 1'b0;
    always #5 cbus.clk = ~cbus.clk;

    initial cbus.ce_3m58_p = 1'b0;
    always @(negedge cbus.clk) begin
        ce_div = (ce_div == 3) ? 0 : ce_div + 1;
        cbus.ce_3m58_p = (ce_div == 0);
    end

    function automatic void check(string nm, int got, int exp_v);
        n_cmp++;
        if (got != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp_v, $time);
        end
    endfunction

    task automatic tick();
        @(posedge cbus.clk);
        while (!cbus.ce_3m58_p) @(posedge cbus.clk);
        #2;
    endtask

    task automatic set_bus(int kind);
        {m1, mreq, iorq, rd, wr} = 5'b0;
        case (kind)
            0: begin m1 = 1; mreq = 1; rd = 1; end
            1: begin mreq = 1; rd = 1; end
            2: begin mreq = 1; wr = 1; end
            3: begin iorq = 1; rd = 1; end
            4: begin iorq = 1; wr = 1; end
            default: begin m1 = 1; iorq = 1; end
        endcase
    endtask

    // Expected WAIT length from the cycle-type rules, then drive the cycle for l ce periods.
    task automatic run_txn(int kind, bit tb_turbo, logic [NS-1:0] req,
                           logic [NS-1:0][CW-1:0] w, int hold_idx, int h, int l,
                           int gap, logic [NS-1:0] noise);
        int   base, n, natural, low;
        bit   holding;
        exp_t e;
        holding = (hold_idx >= 0) && (h > 0);
        if (tb_turbo) base = 0;
        else if (kind == 0 || kind == 5) base = M1W;
        else if (kind == 3 || kind == 4) base = IOW;
        else base = MEMW;
        n = base;
        for (int i = 0; i < NS; i++)
            if (req[i] && int'(w[i]) > n) n = int'(w[i]);
        natural = holding ? ((h < HM) ? h : HM) : n;
        if (l == natural) l++;
        low = (natural < l) ? natural : l;
        if (holding && h > HM && natural < l) tmo_model = 1;
        e.low = low;
        e.tmo = tmo_model;
        e.id  = txn_id++;
        sb_q.push_back(e);

        set_bus(kind);
        turbo     = tb_turbo;
        src_req   = req;
        src_waits = w;
        for (int j = 0; j < l; j++) begin
            ext_hold_n = ~(noise & ~req);
            if (holding && j < h) ext_hold_n[hold_idx] = 1'b0;
            tick();
        end
        {m1, mreq, iorq, rd, wr} = 5'b0;
        ext_hold_n = '1;
        tick();
        repeat (gap) tick();
    endtask

    // Monitor: measure WAIT-low periods per bus cycle and compare at cycle end.
    int   mon_low;
    bit   mon_in, mon_prev, mon_now, mon_busy_bad;
    exp_t mon_e;
    initial begin
        mon_in = 0;
        mon_prev = 0;
        mon_low = 0;
        mon_busy_bad = 0;
        forever begin
            @(posedge cbus.clk);
            if (cbus.ce_3m58_p) begin
                mon_now = (mreq | iorq) & (rd | wr | m1);
                if (reset) begin
                    mon_in = 0;
                    mon_prev = 0;
                end else begin
                    if (mon_now && !mon_prev) begin
                        mon_in = 1;
                        mon_low = 0;
                        mon_busy_bad = 0;
                    end
                    #1;
                    if (mon_in) begin
                        if (!wait_n) mon_low++;
                        if (busy !== !wait_n) mon_busy_bad = 1;
                    end
                    if (!mon_now && mon_prev && mon_in) begin
                        if (sb_q.size() == 0) begin
                            check("sb_unexpected_cycle", 1, 0);
                        end else begin
                            mon_e = sb_q.pop_front();
                            check($sformatf("wait_low#%0d", mon_e.id), mon_low, mon_e.low);
                            check($sformatf("timeout#%0d", mon_e.id), int'(timeout), mon_e.tmo);
                            check($sformatf("busy_track#%0d", mon_e.id), int'(mon_busy_bad), 0);
                        end
                        mon_in = 0;
                    end
                    mon_prev = mon_now;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NS-1:0][CW-1:0] w;
        logic [NS-1:0]         req, noise;
        int                    kind, hidx, h, l, nat, base, n;
        bit                    tb_t;

        reset = 1;
        {m1, mreq, iorq, rd, wr, turbo} = '0;
        src_req = '0;
        src_waits = '0;
        ext_hold_n = '1;
        tick();
        tick();
        check("reset_wait_n", int'(wait_n), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_timeout", int'(timeout), 0);
        reset = 0;
        tick();

        w = '0;
        run_txn(0, 0, 4'b0000, w, -1, 0, 3, 1, 4'b0000);
        w = '0; w[2] = 4'd3;
        run_txn(3, 0, 4'b0100, w, -1, 0, 5, 1, 4'b0000);
        w = '0; w[0] = 4'd2; w[1] = 4'd5;
        run_txn(2, 0, 4'b0011, w, -1, 0, 7, 1, 4'b1100);
        w = '0;
        run_txn(0, 1, 4'b0000, w, -1, 0, 2, 1, 4'b0000);
        w = '0;
        run_txn(1, 0, 4'b0010, w, 1, 10, 12, 1, 4'b0001);
        w = '0; w[0] = 4'd4;
        run_txn(1, 0, 4'b0001, w, -1, 0, 2, 0, 4'b0000);
        w = '0;
        run_txn(0, 0, 4'b0000, w, -1, 0, 2, 1, 4'b0000);
        w = '0;
        run_txn(1, 0, 4'b0010, w, 1, 400, 260, 1, 4'b0000);
        run_txn(0, 0, 4'b0000, w, -1, 0, 3, 1, 4'b0000);

        // Reset during the 2nd WAIT period of a 5-wait I/O cycle.
        w = '0; w[0] = 4'd5;
        set_bus(3);
        src_req = 4'b0001;
        src_waits = w;
        tick();
        tick();
        #3;
        reset = 1;
        {m1, mreq, iorq, rd, wr} = '0;
        #1;
        check("async_reset_wait_n", int'(wait_n), 1);
        check("async_reset_busy", int'(busy), 0);
        check("async_reset_timeout", int'(timeout), 0);
        tmo_model = 0;
        tick();
        tick();
        reset = 0;
        tick();
        w = '0;
        run_txn(0, 0, 4'b0000, w, -1, 0, 3, 1, 4'b0000);

        for (int t = 0; t < 60; t++) begin
            kind = $urandom_range(0, 5);
            tb_t = ($urandom_range(0, 3) == 0);
            req = NS'($urandom);
            noise = NS'($urandom);
            for (int i = 0; i < NS; i++) w[i] = CW'($urandom_range(0, 15));
            hidx = -1;
            h = 0;
            if (req != '0 && $urandom_range(0, 3) == 0) begin
                hidx = $urandom_range(0, NS - 1);
                while (!req[hidx]) hidx = $urandom_range(0, NS - 1);
                h = $urandom_range(1, 20);
            end
            // Rough natural length only to choose an abort point; run_txn owns the expectation.
            if (tb_t) base = 0;
            else if (kind == 0 || kind == 5) base = M1W;
            else if (kind == 3 || kind == 4) base = IOW;
            else base = MEMW;
            n = base;
            for (int i = 0; i < NS; i++)
                if (req[i] && int'(w[i]) > n) n = int'(w[i]);
            nat = (hidx >= 0) ? h : n;
            if (nat > 1 && $urandom_range(0, 3) == 0) l = $urandom_range(1, nat - 1);
            else l = nat + $urandom_range(1, 3);
            run_txn(kind, tb_t, req, w, hidx, h, l, $urandom_range(0, 2), noise);
        end

        tick();
        tick();
        check("sb_drain", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
